// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory handshake between the fetch stage (master) and a
//   variable-latency instruction memory (slave).
//
//   imem_req    fetch request, level; held while a fetch is outstanding
//   imem_addr   word-aligned fetch address; stable while req=1 and ready=0
//   imem_rdata  instruction word, valid in the cycle imem_ready=1
//   imem_ready  response strobe; may rise in the same cycle as the request
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  imem_req;
    logic [31:0]           imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch plus the IF/ID pipeline register of the 5-stage core.
//
//   clk           core clock, rising edge
//   rst           synchronous active-high reset, overrides every other input
//   freeze        hazard stall: hold PC and IF/ID
//   branch_taken  EXE resolved a taken branch: flush IF/ID, redirect PC
//   branch_addr   branch target (low two bits ignored)
//   imem          instruction-memory handshake (master side)
//   if_id_valid   IF/ID holds a real instruction
//   if_id_instr   instruction presented to decode
//   if_id_pc      address of that instruction + 4
//
//   FETCH   : request outstanding at pc_r (addr_r == pc_r).
//   HOLD    : a word arrived while frozen and is parked in the buffer;
//             no request is issued until it is delivered.
//   DISCARD : a branch arrived while a fetch was in flight. The old address
//             stays on the bus until the memory answers, the answer is
//             thrown away, and pc_r already holds the branch target.
//   Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_addr,
    fetch_stage_if.master         imem,
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [31:0]           if_id_pc
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Sequential address; wraps naturally modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // Branch targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    logic [1:0]            state_r,     state_s;
    logic [31:0]           pc_r,        pc_s;
    logic [31:0]           addr_r,      addr_s;
    logic                  req_r,       req_s;
    logic [DATA_WIDTH-1:0] buf_instr_r, buf_instr_s;
    logic [31:0]           buf_pc_r,    buf_pc_s;
    logic                  valid_r,     valid_s;
    logic [DATA_WIDTH-1:0] instr_r,     instr_s;
    logic [31:0]           if_pc_r,     if_pc_s;
    logic [31:0]           seq_pc_s;
    logic [31:0]           target_s;

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = addr_r;
    assign if_id_valid    = valid_r;
    assign if_id_instr    = instr_r;
    assign if_id_pc       = if_pc_r;

    // Next-state, next-PC and next IF/ID contents; branch beats freeze.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        addr_s      = addr_r;
        buf_instr_s = buf_instr_r;
        buf_pc_s    = buf_pc_r;
        valid_s     = valid_r;
        instr_s     = instr_r;
        if_pc_s     = if_pc_r;
        seq_pc_s    = next_word_addr(pc_r);
        target_s    = word_align(branch_addr);

        if (branch_taken) begin
            valid_s = 1'b0;
            instr_s = {DATA_WIDTH{1'b0}};
            pc_s    = target_s;
            case (state_r)
                ST_FETCH, ST_DISCARD: begin
                    // An answer this cycle is dropped and the target can be
                    // requested at once; otherwise drain the old fetch first.
                    if (imem.imem_ready) begin
                        state_s = ST_FETCH;
                        addr_s  = target_s;
                    end else begin
                        state_s = ST_DISCARD;
                        addr_s  = addr_r;
                    end
                end
                ST_HOLD: begin
                    state_s     = ST_FETCH;
                    addr_s      = target_s;
                    buf_instr_s = {DATA_WIDTH{1'b0}};
                    buf_pc_s    = 32'h0000_0000;
                end
                default: begin
                    state_s = ST_FETCH;
                    addr_s  = target_s;
                end
            endcase
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        pc_s   = seq_pc_s;
                        addr_s = seq_pc_s;
                        if (freeze) begin
                            // Decode cannot take it: park the word.
                            buf_instr_s = imem.imem_rdata;
                            buf_pc_s    = seq_pc_s;
                            state_s     = ST_HOLD;
                        end else begin
                            valid_s = 1'b1;
                            instr_s = imem.imem_rdata;
                            if_pc_s = seq_pc_s;
                            state_s = ST_FETCH;
                        end
                    end else begin
                        if (freeze) begin
                            valid_s = valid_r;
                        end else begin
                            valid_s = 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (freeze) begin
                        state_s = ST_HOLD;
                    end else begin
                        // pc_r/addr_r already point past the parked word.
                        valid_s = 1'b1;
                        instr_s = buf_instr_r;
                        if_pc_s = buf_pc_r;
                        state_s = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    valid_s = 1'b0;
                    if (imem.imem_ready) begin
                        state_s = ST_FETCH;
                        addr_s  = pc_r;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end
                default: begin
                    state_s = ST_FETCH;
                    addr_s  = pc_r;
                    valid_s = 1'b0;
                end
            endcase
        end

        if (state_s == ST_HOLD) begin
            req_s = 1'b0;
        end else begin
            req_s = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            addr_r      <= RESET_PC;
            req_r       <= 1'b1;
            buf_instr_r <= {DATA_WIDTH{1'b0}};
            buf_pc_r    <= 32'h0000_0000;
            valid_r     <= 1'b0;
            instr_r     <= {DATA_WIDTH{1'b0}};
            if_pc_r     <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            addr_r      <= addr_s;
            req_r       <= req_s;
            buf_instr_r <= buf_instr_s;
            buf_pc_r    <= buf_pc_s;
            valid_r     <= valid_s;
            instr_r     <= instr_s;
            if_pc_r     <= if_pc_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Drives fetch_stage with a wait-state memory and checks every cycle
//   against a program-order reference model: the next address to fetch,
//   an optional in-flight address being drained after a branch, and an
//   optional parked word.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;

    fetch_stage_if #(.DATA_WIDTH(32)) mif ();

    fetch_stage #(.RESET_PC(RESET_PC), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (mif),
        .if_id_valid  (if_id_valid),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    string step_name = "init";

    // Memory environment
    logic [31:0] data_xor   = 32'h0;
    int          fixed_wait = 0;   // <0 : random 0..3 per fetch
    int          cur_wait   = 0;
    int          waited     = 0;

    // Reference model
    logic [31:0] m_pc, m_drain_addr, m_pk_instr, m_pk_pc, m_instr, m_ifpc;
    bit          m_drain, m_parked, m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ data_xor;
    endfunction

    function automatic int pick_wait();
        if (fixed_wait >= 0) return fixed_wait;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %h expected %h", step_name, name, got, exp);
        end
    endtask

    task automatic drive_mem();
        if (mif.imem_req === 1'b1) begin
            mif.imem_ready = (waited >= cur_wait);
            mif.imem_rdata = mem_word(mif.imem_addr);
        end else begin
            mif.imem_ready = 1'b0;
            mif.imem_rdata = 32'h0;
        end
    endtask

    task automatic set_wait_now(input int n);
        cur_wait = n;
        waited   = 0;
        drive_mem();
    endtask

    task automatic model_update(input bit rdy);
        if (rst) begin
            m_pc = RESET_PC; m_drain = 0; m_parked = 0;
            m_valid = 0; m_instr = 32'h0; m_ifpc = 32'h0;
        end else if (branch_taken) begin
            m_valid = 0; m_instr = 32'h0;
            if (m_parked) begin
                m_parked = 0;
            end else if (m_drain) begin
                if (rdy) m_drain = 0;
            end else if (!rdy) begin
                m_drain = 1; m_drain_addr = m_pc;
            end
            m_pc = {branch_addr[31:2], 2'b00};
        end else if (m_drain) begin
            m_valid = 0;
            if (rdy) m_drain = 0;
        end else if (m_parked) begin
            if (!freeze) begin
                m_valid = 1; m_instr = m_pk_instr; m_ifpc = m_pk_pc; m_parked = 0;
            end
        end else if (rdy) begin
            if (freeze) begin
                m_parked = 1; m_pk_instr = mem_word(m_pc); m_pk_pc = m_pc + 32'd4;
            end else begin
                m_valid = 1; m_instr = mem_word(m_pc); m_ifpc = m_pc + 32'd4;
            end
            m_pc = m_pc + 32'd4;
        end else if (!freeze) begin
            m_valid = 0;
        end
    endtask

    task automatic check();
        cmp("req", {31'h0, mif.imem_req}, {31'h0, !m_parked});
        if (!m_parked) cmp("addr", mif.imem_addr, m_drain ? m_drain_addr : m_pc);
        cmp("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        cmp("instr", if_id_instr, m_instr);
        cmp("if_pc", if_id_pc, m_ifpc);
    endtask

    // One clock: update memory and model at the edge, check 1 time unit later.
    task automatic tick();
        bit req_q, rdy_q;
        req_q = (mif.imem_req === 1'b1);
        rdy_q = (mif.imem_ready === 1'b1);
        @(posedge clk);
        model_update(rdy_q && req_q);
        if (rst || (req_q && rdy_q)) begin
            waited = 0; cur_wait = pick_wait();
        end else if (req_q) begin
            waited++;
        end
        #1;
        check();
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        mif.imem_ready = 1'b0; mif.imem_rdata = 32'h0;

        // Reset state, then zero-wait memory with addr-as-data.
        step_name = "reset";
        fixed_wait = 0;
        tick(); tick();
        rst = 1'b0;
        step_name = "zero_wait";
        repeat (5) tick();

        // Two wait states per fetch.
        step_name = "two_wait";
        fixed_wait = 2;
        do_reset();
        repeat (10) tick();

        // Freeze while fetch of 8 completes.
        step_name = "freeze";
        fixed_wait = 0;
        do_reset();
        tick(); tick();          // fetched 0,4; 8 on the bus
        freeze = 1'b1;
        repeat (3) tick();
        freeze = 1'b0;
        repeat (3) tick();

        // Branch to 0x103 while a 3-wait fetch of 0x20 is outstanding.
        step_name = "branch_discard";
        fixed_wait = 0;
        data_xor = 32'hA5A5_0000;
        do_reset();
        for (int i = 0; i < 20 && m_pc != 32'h20; i++) tick();
        cmp("reach_0x20", m_pc, 32'h20);
        set_wait_now(3);
        tick();
        branch_taken = 1'b1; branch_addr = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        repeat (5) tick();

        // Branch and freeze together while a word is parked.
        step_name = "branch_in_hold";
        do_reset();
        tick(); tick();
        freeze = 1'b1;
        tick(); tick();
        branch_taken = 1'b1; branch_addr = 32'h0000_0040;
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        repeat (3) tick();

        // PC wrap at the top of the address space.
        step_name = "pc_wrap";
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        repeat (3) tick();

        // Reset while draining a fetch.
        step_name = "rst_in_discard";
        fixed_wait = 3;
        do_reset();
        tick();
        branch_taken = 1'b1; branch_addr = 32'h0000_0080;
        tick();
        branch_taken = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Randomized traffic.
        step_name = "random";
        fixed_wait = -1;
        data_xor = $urandom;
        drive_mem();
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            freeze       = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            branch_addr  = $urandom;
            tick();
        end
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
